adder_pipe: RTL and testbench
=============================

// Module: adder_pipe
// PURPOSE
//  Pipelined, handshaked N-bit add/subtract unit; successor to the single-cycle ripple adder.
//  Splits the carry chain into STAGES register-separated slices so wide datapaths close timing.
//  Sits between the ALU operand muxes and the writeback path; valid/ready on both sides.
// PARAMETERS
//  N       18  operand/result width in bits (N >= 1)
//  STAGES  3   pipeline depth = number of carry slices (1 <= STAGES <= N)
// PORTS
//  clk        in   1  single clock, all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  operands valid this cycle
//  in_ready   out  1  unit accepts operands this cycle
//  a          in   N  operand A
//  b          in   N  operand B
//  cin        in   1  carry in (ignored when sub=1)
//  sub        in   1  0: a+b+cin   1: a-b (a + ~b + 1)
//  out_valid  out  1  result valid
//  out_ready  in   1  downstream accepts result
//  sum        out  N  result, modulo 2^N
//  cout       out  1  carry out of bit N-1 (sub: 1 = no borrow)
//  ovf        out  1  signed overflow (only with ADDER_PIPE_OVF_EN)
// BEHAVIOUR
//  - Reset (async assert, sync-safe release): all stage valids 0; out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
//  - Slice width W = ceil(N/STAGES); slices 0..STAGES-2 are W bits, last slice holds the remainder (>=1 bit).
//    Slice indices beyond N collapse: if ceil leaves an empty slice, STAGES is illegal -> elaboration error.
//  - Stage k adds slice k of A/B' plus carry from stage k-1 register; lower result bits travel forward,
//    upper unconsumed operand bits are delayed alongside. B' = sub ? ~b : b; c0 = sub ? 1 : cin.
//  - Transfer on a side occurs when valid && ready in the same cycle.
//  - Stage k register loads when it is empty or stage k+1 drains: ready_k = !valid_k || ready_{k+1};
//    ready_STAGES = out_ready; in_ready = ready_0. Bubbles collapse; no combinational path in_valid->out_valid.
//  - Latency: exactly STAGES cycles from accept to out_valid when out_ready held 1; throughput 1/cycle.
//  - Backpressure: out_ready=0 holds sum/cout/ovf/out_valid stable; pipeline fills, in_ready drops once
//    all STAGES registers valid; no result lost or duplicated, order preserved.
//  - Simultaneous accept and drain on a full pipe: both occur, occupancy unchanged.
//  - out_valid deasserts only after a transfer with no newer result behind it.
//  - Reset mid-operation discards all in-flight results; first accept after release behaves as from empty.
//  - Wrap-around: sum is modulo 2^N, carry reported only via cout.
// CONFIGURATION
//  ADDER_PIPE_OVF_EN defined: port ovf present; ovf = (A'[N-1]==B'[N-1]) && (sum[N-1]!=A'[N-1]),
//    computed in last stage, registered with sum, same latency and stall behaviour.
//  Not defined: port ovf absent, no sign bits carried down the pipe.
// STRUCTURE
//  Shared package alu_pkg: default width constant ALU_W=18, op encoding (ALU_ADD=0, ALU_SUB=1).
//  One sub-module: adder_pipe_slice (parametrised W-bit add: a, b, cin -> sum, cout), built on
//  full_adder chain; instantiated STAGES times via generate.
//  Stage registers, valid/ready chain and optional ovf logic live in adder_pipe.
// TESTING (N=18, STAGES=3 unless noted)
//  - a=0x3FFFF, b=0, cin=1, sub=0, out_ready=1 -> sum=0x00000, cout=1, out_valid exactly 3 cycles later.
//  - a=5, b=7, sub=1 -> sum=0x3FFFE, cout=0; a=7, b=5, sub=1 -> sum=2, cout=1.
//  - 6 back-to-back inputs, out_ready=0 for 5 cycles -> in_ready low after 3 accepts, all 6 results in order.
//  - Assert rst_n=0 with 2 results in flight -> out_valid=0 immediately, no stale result after release.
//  - OVF_EN: a=0x1FFFF, b=1, sub=0 -> ovf=1; a=0x20000, b=1, sub=1 -> ovf=1; a=3, b=1 -> ovf=0.
//  - N=8, STAGES=1 random 1000 ops vs reference model, random out_ready -> exact match, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU width, add/sub op encoding and a sizing helper
package alu_pkg;

    localparam int ALU_W = 18;

    typedef enum logic {
        ALU_ADD = 1'b0,
        ALU_SUB = 1'b1
    } alu_op_e;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/adder_pipe_slice.sv
// rtl/adder_pipe_slice.sv - W-bit ripple-carry slice built from a full_adder chain
module adder_pipe_slice #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout = c[W];

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - single-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined valid/ready add/subtract, carry chain split into STAGES slices
// Optional signed-overflow output enabled by defining ADDER_PIPE_OVF_EN.
module adder_pipe
    import alu_pkg::*;
#(
    parameter int N      = ALU_W,
    parameter int STAGES = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int W      = (STAGES > 0) ? ceil_div(N, STAGES) : 1;
    localparam int LAST_W = N - W * (STAGES - 1);

    if (STAGES < 1 || LAST_W < 1) begin : g_bad_cfg
        $error("adder_pipe: STAGES=%0d leaves an empty slice for N=%0d", STAGES, N);
    end

    alu_op_e        op;
    logic [N-1:0]   bp;
    logic           c0;
    logic [STAGES:0] rdy;

    // Subtraction is a + ~b + 1, so the incoming cin is ignored for sub.
    assign op       = alu_op_e'(sub);
    assign bp       = (op == ALU_SUB) ? ~b : b;
    assign c0       = (op == ALU_SUB) ? 1'b1 : cin;
    assign rdy[STAGES] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * W;
        localparam int HI = (k == STAGES - 1) ? N - 1 : LO + W - 1;

        logic [N-1:LO] ai;
        logic [N-1:LO] bi;
        logic          ci;
        logic          vin;
        logic [HI:LO]  snew;
        logic          cnew;
        logic [HI:0]   s_next;
        logic [HI:0]   s_q;
        logic          c_q;
        logic          v_q;

        // ai/bi hold only the operand bits not yet consumed by earlier slices.
        if (k == 0) begin : g_src
            assign ai     = a;
            assign bi     = bp;
            assign ci     = c0;
            assign vin    = in_valid;
            assign s_next = snew;
        end else begin : g_src
            assign ai     = g_st[k-1].g_op.a_q;
            assign bi     = g_st[k-1].g_op.b_q;
            assign ci     = g_st[k-1].c_q;
            assign vin    = g_st[k-1].v_q;
            assign s_next = {snew, g_st[k-1].s_q};
        end

        adder_pipe_slice #(.W(HI - LO + 1)) u_slice (
            .a    (ai[HI:LO]),
            .b    (bi[HI:LO]),
            .cin  (ci),
            .sum  (snew),
            .cout (cnew)
        );

        assign rdy[k] = !v_q || rdy[k+1];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                c_q <= 1'b0;
                s_q <= '0;
            end else if (rdy[k]) begin
                v_q <= vin;
                if (vin) begin
                    c_q <= cnew;
                    s_q <= s_next;
                end
            end
        end

        if (k < STAGES - 1) begin : g_op
            logic [N-1:HI+1] a_q;
            logic [N-1:HI+1] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (rdy[k] && vin) begin
                    a_q <= ai[N-1:HI+1];
                    b_q <= bi[N-1:HI+1];
                end
            end
        end else begin : g_out
            assign sum       = s_q;
            assign cout      = c_q;
            assign out_valid = v_q;

`ifdef ADDER_PIPE_OVF_EN
            // Sign bits of A and B' are the top operand bits consumed by this last slice.
            logic ovf_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q <= 1'b0;
                end else if (rdy[k] && vin) begin
                    ovf_q <= (ai[N-1] == bi[N-1]) && (s_next[N-1] != ai[N-1]);
                end
            end

            assign ovf = ovf_q;
`endif
        end
    end

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (18b/3 stages and 8b/1 stage)
module tb_adder_pipe;

    localparam int N = 18;
    localparam int S = 3;
    localparam int M = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
    logic [N-1:0] a, b, sum;
    logic in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8;
    logic [M-1:0] a8, b8, sum8;
`ifdef ADDER_PIPE_OVF_EN
    logic ovf, ovf8;
`endif

    typedef struct {
        longint sum;
        logic   cout;
        logic   ovf;
        int     acc;
        bit     lat;
    } exp_t;

    exp_t q[$];
    exp_t q8[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    bit   stop = 1'b0;

    adder_pipe #(.N(N), .STAGES(S)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf)
`endif
    );

    adder_pipe #(.N(M), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(ovf8)
`endif
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, checks so far %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Arithmetic reference: unsigned result/carry and signed range check.
    function automatic exp_t model(input int n, input longint x, input longint y,
                                   input bit ci, input bit sb);
        exp_t   e;
        longint m = longint'(1) << n;
        longint c = ci;
        longint r, sx, sy, sr;
        if (sb) begin
            r      = x - y;
            e.cout = (x >= y);
        end else begin
            r      = x + y + c;
            e.cout = (r >= m);
        end
        e.sum = r & (m - 1);
        sx    = (x >= m / 2) ? x - m : x;
        sy    = (y >= m / 2) ? y - m : y;
        sr    = sb ? sx - sy : sx + sy + c;
        e.ovf = (sr >= m / 2) || (sr < -(m / 2));
        e.acc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    task automatic send(input logic [N-1:0] xa, input logic [N-1:0] xb,
                        input bit xc, input bit xs, input bit lat);
        exp_t e;
        int   t = 0;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        else begin
            e = model(N, xa, xb, xc, xs);
            e.acc = cyc;
            e.lat = lat;
            q.push_back(e);
            n_acc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [M-1:0] xa, input logic [M-1:0] xb,
                         input bit xc, input bit xs);
        exp_t e;
        int   t = 0;
        a8 = xa; b8 = xb; cin8 = xc; sub8 = xs; in_valid8 = 1'b1;
        @(negedge clk);
        while (!in_ready8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready8) chk("accept_timeout8", in_ready8, 1);
        else begin
            e = model(M, xa, xb, xc, xs);
            e.acc = cyc;
            e.lat = 1'b1;
            q8.push_back(e);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0 || q8.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_left", q.size() + q8.size(), 0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
    endtask

    // Monitor for the 18-bit pipe: ordering, values, latency and stall stability.
    bit            pend = 1'b0;
    bit            stall = 1'b0;
    int            first = 0;
    logic [N-1:0]  sum_h;
    logic          cout_h;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            pend  = 1'b0;
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_sum", sum, sum_h);
                chk("hold_cout", cout, cout_h);
            end
            if (out_valid && !pend) begin
                pend  = 1'b1;
                first = cyc;
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("spurious_result", q.size(), 1);
                else begin
                    e = q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
`ifdef ADDER_PIPE_OVF_EN
                    chk("ovf", ovf, e.ovf);
`endif
                    if (e.lat) chk("latency", first - e.acc, S);
                end
                pend = 1'b0;
            end
            stall  = out_valid && !out_ready;
            sum_h  = sum;
            cout_h = cout;
        end
    end

    bit pend8 = 1'b0;
    int first8 = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) pend8 = 1'b0;
        else begin
            if (out_valid8 && !pend8) begin
                pend8  = 1'b1;
                first8 = cyc;
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) chk("spurious_result8", q8.size(), 1);
                else begin
                    e = q8.pop_front();
                    chk("sum8", sum8, e.sum);
                    chk("cout8", cout8, e.cout);
`ifdef ADDER_PIPE_OVF_EN
                    chk("ovf8", ovf8, e.ovf);
`endif
                    chk("latency8", first8 - e.acc, 1);
                end
                pend8 = 1'b0;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid8", out_valid8, 0);
`ifdef ADDER_PIPE_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // Directed corners, back-to-back with the output always ready.
        send(18'h3FFFF, 18'h00000, 1'b1, 1'b0, 1'b1);
        send(18'h00005, 18'h00007, 1'b0, 1'b1, 1'b1);
        send(18'h00007, 18'h00005, 1'b0, 1'b1, 1'b1);
        send(18'h00007, 18'h00005, 1'b1, 1'b1, 1'b1);
        send(18'h1FFFF, 18'h00001, 1'b0, 1'b0, 1'b1);
        send(18'h20000, 18'h00001, 1'b0, 1'b1, 1'b1);
        send(18'h00003, 18'h00001, 1'b0, 1'b0, 1'b1);
        send(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0, 1'b1);
        send(18'h00FC0, 18'h0003F, 1'b1, 1'b0, 1'b1);
        drain();

        // Backpressure: six back-to-back with the output blocked for five cycles.
        out_ready = 1'b0;
        n_acc = 0;
        fork
            for (int i = 0; i < 6; i++)
                send(N'($urandom), N'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
            begin
                repeat (5) @(negedge clk);
                #2;
                chk("bp_accepts", n_acc, 3);
                chk("bp_in_ready", in_ready, 0);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two results in flight, one of them waiting at the output.
        out_ready = 1'b0;
        send(N'($urandom), N'($urandom), 1'b0, 1'b0, 1'b0);
        send(N'($urandom), N'($urandom), 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("pre_rst_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sum", sum, 0);
        q.delete();
        repeat (3) @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(18'h12345, 18'h0ABCD, 1'b1, 1'b0, 1'b1);
        drain();

        // Random traffic on the 3-stage pipe with random output stalls.
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(N'($urandom), N'($urandom), $urandom_range(0, 1), $urandom_range(0, 1), 1'b0);
                end
                stop = 1'b1;
            end
            while (!stop) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Random traffic on the 8-bit single-stage pipe.
        stop = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 4) == 0) begin
                        @(posedge clk); #1;
                    end
                    send8(M'($urandom), M'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
                end
                stop = 1'b1;
            end
            while (!stop) begin
                out_ready8 = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
        join
        out_ready8 = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
